// File: rtl/gpio_cond_pkg.sv
// rtl/gpio_cond_pkg.sv - register map, reset value and edge codes for gpio_in_cond
package gpio_cond_pkg;

    localparam logic [3:0]  ADDR_CLEAN   = 4'h0;
    localparam logic [3:0]  ADDR_RISE_EN = 4'h4;
    localparam logic [3:0]  ADDR_FALL_EN = 4'h8;
    localparam logic [3:0]  ADDR_STATUS  = 4'hC;

    localparam logic [31:0] REG_RESET    = 32'h0000_0000;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - per-bit synchroniser, debounce counter (GPIO_IN_COND_DEBOUNCE_EN) and edge code
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  pad_i,
    output logic  clean_o,
    output edge_e edge_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("gpio_debounce_bit: SYNC_STAGES must be at least 2");
    end
    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("gpio_debounce_bit: DEB_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   clean_q, clean_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
            clean_q <= clean_d;
        end
    end

`ifdef GPIO_IN_COND_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any return to the accepted level restarts qualification from zero.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = cnt_q;
        if (sync == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            clean_d = sync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        clean_d = sync;
    end
`endif

    // Edge code describes the update being registered this cycle.
    always_comb begin
        edge_o = EDGE_NONE;
        if (clean_d && !clean_q) begin
            edge_o = EDGE_RISE;
        end else if (!clean_d && clean_q) begin
            edge_o = EDGE_FALL;
        end
    end

    assign clean_o = clean_q;

endmodule

// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - GPIO input conditioning top with register window and edge irq; debounce under GPIO_IN_COND_DEBOUNCE_EN
module gpio_in_cond
    import gpio_cond_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] gpio_in_clean,
    output logic             irq
);

    logic [WIDTH-1:0] clean_w;
    edge_e            edge_w [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .pad_i   (pad_in[i]),
            .clean_o (clean_w[i]),
            .edge_o  (edge_w[i])
        );
    end

    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] set_w, clr_w;
    logic [31:0]      rdata_q, rd_mux;

    always_comb begin
        set_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set_w[i] = ((edge_w[i] == EDGE_RISE) && rise_en_q[i]) ||
                       ((edge_w[i] == EDGE_FALL) && fall_en_q[i]);
        end
    end

    // Set is OR-ed after the clear so a same-cycle edge survives W1C.
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_w     = '0;
        if (we) begin
            case (addr)
                ADDR_RISE_EN: rise_en_d = wdata[WIDTH-1:0];
                ADDR_FALL_EN: fall_en_d = wdata[WIDTH-1:0];
                ADDR_STATUS:  clr_w     = wdata[WIDTH-1:0];
                default:      ;
            endcase
        end
        status_d = (status_q & ~clr_w) | set_w;
    end

    always_comb begin
        rd_mux = REG_RESET;
        case (addr)
            ADDR_CLEAN:   rd_mux = 32'(clean_w);
            ADDR_RISE_EN: rd_mux = 32'(rise_en_q);
            ADDR_FALL_EN: rd_mux = 32'(fall_en_q);
            ADDR_STATUS:  rd_mux = 32'(status_q);
            default:      rd_mux = REG_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en_q <= REG_RESET[WIDTH-1:0];
            fall_en_q <= REG_RESET[WIDTH-1:0];
            status_q  <= REG_RESET[WIDTH-1:0];
            rdata_q   <= REG_RESET;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            if (re) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign rdata         = rdata_q;
    assign gpio_in_clean = clean_w;
    assign irq           = |status_q;

endmodule
